// File: rtl/bcd_counter_n.sv
// bcd_counter_n: multi-digit cascaded BCD up/down counter with synchronous
// parallel load, wrap-or-saturate terminal behaviour, a combinational
// terminal-count output for cascading, and a sticky overflow flag.
module bcd_counter_n #(
    parameter int NUM_DIGITS = 2,  // 1..8 decimal digits
    parameter int SATURATE   = 0   // 0: wrap at terminal, 1: hold at terminal
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] cnt,
    output logic                    tc,
    output logic                    ovf
);

    localparam int W = 4 * NUM_DIGITS;
    localparam logic [W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

    logic [W-1:0] r_cnt;
    logic         r_ovf;
    logic [W-1:0] w_step;
    logic [W-1:0] w_load_bcd;
    logic         w_at_term;

    // Terminal value depends on direction: all nines going up, all zeros going down.
    always_comb begin
        w_at_term = up_dn ? (r_cnt == ALL_NINES) : (r_cnt == '0);
    end

    // Single-cycle ripple: each digit steps only when every lower digit rolled over.
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the tool infers a latch to hold it.
    always_comb begin
        logic w_carry;
        w_step  = r_cnt;
        w_carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_carry) begin
                if (up_dn) begin
                    if (r_cnt[4*i +: 4] == 4'd9) begin
                        w_step[4*i +: 4] = 4'd0;
                    end else begin
                        w_step[4*i +: 4] = r_cnt[4*i +: 4] + 4'd1;
                        w_carry          = 1'b0;
                    end
                end else begin
                    if (r_cnt[4*i +: 4] == 4'd0) begin
                        w_step[4*i +: 4] = 4'd9;
                    end else begin
                        w_step[4*i +: 4] = r_cnt[4*i +: 4] - 4'd1;
                        w_carry          = 1'b0;
                    end
                end
            end
        end
    end

    // Load value clamped digit by digit so only valid BCD can enter the counter.
    always_comb begin
        w_load_bcd = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_load_bcd[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
        end
    end

    // Combinational terminal count, feeds the enable of the next cascaded stage.
    always_comb begin
        tc = en & ~load & ~rst & w_at_term;
    end

    // Count/ovf state: priority rst > load > en > hold.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (load) begin
            r_cnt <= w_load_bcd;
            r_ovf <= 1'b0;
        end else if (en) begin
            if (w_at_term) begin
                r_ovf <= 1'b1;
                if (SATURATE == 0) begin
                    r_cnt <= w_step;
                end
            end else begin
                r_cnt <= w_step;
            end
        end
    end

    assign cnt = r_cnt;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n (2 digits): a wrapping and a saturating instance
// share the same stimulus; an integer-valued model is checked every cycle,
// and directed literal expectations pin the model.
module tb_bcd_counter_n;

    localparam int ND = 2;
    localparam int W  = 4 * ND;
    localparam int MAXV = 99;

    logic         clk = 1'b0;
    logic         rst, en, up_dn, load;
    logic [W-1:0] load_val;
    logic [W-1:0] cnt_w, cnt_s;
    logic         tc_w, tc_s, ovf_w, ovf_s;

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    always #5 clk = ~clk;

    bcd_counter_n #(.NUM_DIGITS(ND), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .cnt(cnt_w), .tc(tc_w), .ovf(ovf_w)
    );

    bcd_counter_n #(.NUM_DIGITS(ND), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .cnt(cnt_s), .tc(tc_s), .ovf(ovf_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (integer value 0..99) ----------------
    int m_val [2];
    bit m_ovf [2];
    bit m_valid = 1'b0;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [3:0] tens, ones;
        tens = 4'(v / 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

    function automatic int clamp_load(input logic [W-1:0] lv);
        int hi, lo;
        hi = int'(lv[7:4]);
        lo = int'(lv[3:0]);
        if (hi > 9) hi = 9;
        if (lo > 9) lo = 9;
        return hi * 10 + lo;
    endfunction

    function automatic bit model_tc(input int v, input bit r, input bit l, input bit e, input bit ud);
        return e && !l && !r && (ud ? (v == MAXV) : (v == 0));
    endfunction

    // Compare process: advance the model with the inputs present at the edge,
    // then check both instances shortly after the edge.
    initial begin
        logic s_rst, s_en, s_ud, s_load;
        logic [W-1:0] s_lv;
        while (!done) begin
            @(posedge clk);
            s_rst = rst; s_en = en; s_ud = up_dn; s_load = load; s_lv = load_val;
            #1;
            for (int k = 0; k < 2; k++) begin
                if (s_rst) begin
                    m_val[k] = 0;
                    m_ovf[k] = 1'b0;
                end else if (s_load) begin
                    m_val[k] = clamp_load(s_lv);
                    m_ovf[k] = 1'b0;
                end else if (s_en) begin
                    if (s_ud) begin
                        if (m_val[k] == MAXV) begin
                            m_ovf[k] = 1'b1;
                            m_val[k] = (k == 1) ? MAXV : 0;
                        end else m_val[k] = m_val[k] + 1;
                    end else begin
                        if (m_val[k] == 0) begin
                            m_ovf[k] = 1'b1;
                            m_val[k] = (k == 1) ? 0 : MAXV;
                        end else m_val[k] = m_val[k] - 1;
                    end
                end
            end
            if (s_rst) m_valid = 1'b1;
            if (m_valid && !done) begin
                check("model cnt wrap", cnt_w, to_bcd(m_val[0]));
                check("model ovf wrap", ovf_w, m_ovf[0]);
                check("model tc wrap", tc_w, model_tc(m_val[0], rst, load, en, up_dn));
                check("model cnt sat", cnt_s, to_bcd(m_val[1]));
                check("model ovf sat", ovf_s, m_ovf[1]);
                check("model tc sat", tc_s, model_tc(m_val[1], rst, load, en, up_dn));
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic set_in(input logic r, input logic l, input logic [W-1:0] lv,
                          input logic e, input logic ud);
        rst = r; load = l; load_val = lv; en = e; up_dn = ud;
    endtask

    initial begin
        set_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        // 1. reset two cycles, then count up 100 cycles
        repeat (2) @(negedge clk);
        check("reset cnt", cnt_w, 8'h00);
        check("reset ovf", ovf_w, 1'b0);
        check("reset tc", tc_w, 1'b0);
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        repeat (9) @(negedge clk);
        check("up 09", cnt_w, 8'h09);
        @(negedge clk);
        check("up 10 ripple", cnt_w, 8'h10);
        repeat (89) @(negedge clk);
        check("up 99", cnt_w, 8'h99);
        check("up tc at 99", tc_w, 1'b1);
        check("up ovf before wrap", ovf_w, 1'b0);
        @(negedge clk);
        check("up wrap 00", cnt_w, 8'h00);
        check("up ovf after wrap", ovf_w, 1'b1);
        check("sat hold 99", cnt_s, 8'h99);

        // 2. load 47, count down 48 cycles
        set_in(1'b0, 1'b1, 8'h47, 1'b0, 1'b1);
        @(negedge clk);
        check("load 47", cnt_w, 8'h47);
        check("load clears ovf", ovf_w, 1'b0);
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        check("down 39 borrow", cnt_w, 8'h39);
        repeat (39) @(negedge clk);
        check("down 00", cnt_w, 8'h00);
        check("down tc at 00", tc_w, 1'b1);
        @(negedge clk);
        check("down wrap 99", cnt_w, 8'h99);
        check("down ovf", ovf_w, 1'b1);
        check("sat down hold 00", cnt_s, 8'h00);

        // 3. load clamping of non-BCD digits
        set_in(1'b0, 1'b1, 8'hA3, 1'b0, 1'b0);
        @(negedge clk);
        check("clamp A3", cnt_w, 8'h93);
        check("clamp ovf", ovf_w, 1'b0);
        set_in(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        check("clamp FF", cnt_w, 8'h99);
        set_in(1'b0, 1'b1, 8'h5C, 1'b0, 1'b0);
        @(negedge clk);
        check("clamp 5C", cnt_w, 8'h59);

        // 4. saturate: load 98, count up 4 cycles
        set_in(1'b0, 1'b1, 8'h98, 1'b0, 1'b1);
        @(negedge clk);
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("sat cnt 99", cnt_s, 8'h99);
        check("sat ovf", ovf_s, 1'b1);
        check("sat tc", tc_s, 1'b1);
        check("wrap past 98", cnt_w, 8'h02);

        // 5. count to 37, then reset with en and load high
        set_in(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        repeat (37) @(negedge clk);
        check("count to 37", cnt_w, 8'h37);
        set_in(1'b1, 1'b1, 8'h88, 1'b1, 1'b1);
        @(negedge clk);
        check("mid reset cnt", cnt_w, 8'h00);
        check("mid reset ovf", ovf_w, 1'b0);
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        check("resume 01", cnt_w, 8'h01);

        // 6. hold at 55 with up_dn toggling, then load beats en
        set_in(1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            set_in(1'b0, 1'b0, 8'h00, 1'b0, i[0]);
            @(negedge clk);
            check("hold 55", cnt_w, 8'h55);
            check("hold tc", tc_w, 1'b0);
        end
        set_in(1'b0, 1'b1, 8'h12, 1'b1, 1'b1);
        check("tc low on load", tc_w, 1'b0);
        @(negedge clk);
        check("load beats en", cnt_w, 8'h12);

        // direction change takes effect on the very next edge
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        check("dir change", cnt_w, 8'h11);

        done = 1'b1;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
